piso_frame_ctrl: RTL

Frame controller and sequencer for the 5-bit parallel-in/serial-out shift path. It accepts parallel words over a valid/ready handshake and loads them into an internal shift register. It then shifts each word out LSB-first inside a framed serial stream: start bit, data, optional parity, stop bit(s). Each bit is held for a programmable number of clock cycles. It sits between a word-producing client and a single-wire serial output.

---
 rtl/piso_frame_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/piso_frame_ctrl.sv
// Framed serial transmitter: accepts a parallel word over valid/ready and shifts it
// out LSB-first as start bit, data, optional parity and stop bit(s), each held CLKS_PER_BIT clocks.
module piso_frame_ctrl #(
  parameter int DATA_W       = 5,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              so,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends on state (and rst) only; the producer holds in_data/in_valid until taken.

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              par_q, par_d;
  logic              so_q, so_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic hs;
  logic bit_end;
  logic data_last;
  logic stop_last;

  assign in_ready    = (state_q == IDLE) && !rst;
  assign hs          = in_valid && in_ready;
  assign bit_end     = (div_cnt_q == DIV_LAST);
  assign data_last   = (bit_cnt_q == DATA_LAST);
  assign stop_last   = (bit_cnt_q == STOP_LAST);
  assign so          = so_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && data_last) state_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end && stop_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    so_d      = so_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_cnt_d = bit_end ? '0 : div_cnt_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        so_d      = 1'b1;
        busy_d    = 1'b0;
        if (hs) begin
          sr_d   = in_data;
          par_d  = 1'b0;
          so_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          so_d      = sr_q[0];
          par_d     = par_q ^ sr_q[0];
          sr_d      = {1'b0, sr_q[DATA_W-1:1]};
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (!data_last) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            so_d      = sr_q[0];
            par_d     = par_q ^ sr_q[0];
            sr_d      = {1'b0, sr_q[DATA_W-1:1]};
          end else if (PARITY != 0) begin
            so_d = (PARITY == 2) ? ~par_q : par_q;
          end else begin
            so_d      = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          so_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!stop_last) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            so_d      = 1'b1;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        so_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset aborts any frame and returns the line to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      par_q     <= 1'b0;
      so_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      par_q     <= par_d;
      so_q      <= so_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
